// File: rtl/tinyqv_decode_stage.sv
// tinyQV instruction decode stage: combinational RV32I/E decode
// feeding a two-entry skid buffer so in_ready comes from a flop.
module tinyqv_decode_stage #(
  parameter int REG_ADDR_BITS = 4,
  parameter int PC_BITS       = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_BITS-1:0]       in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_BITS-1:0]       out_pc,
  output logic [31:0]              imm,
  output logic                     is_load,
  output logic                     is_alu_imm,
  output logic                     is_auipc,
  output logic                     is_store,
  output logic                     is_alu_reg,
  output logic                     is_lui,
  output logic                     is_branch,
  output logic                     is_jalr,
  output logic                     is_jal,
  output logic                     is_system,
  output logic                     is_illegal,
  output logic [2:0]               instr_len,
  output logic [3:0]               alu_op,
  output logic [2:0]               mem_op,
  output logic [REG_ADDR_BITS-1:0] rs1,
  output logic [REG_ADDR_BITS-1:0] rs2,
  output logic [REG_ADDR_BITS-1:0] rd
);

  localparam int N     = REG_ADDR_BITS;
  localparam bit RV32E = (N == 4);

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [31:0]        imm;
    logic [9:0]         cls;
    logic               ill;
    logic [2:0]         len;
    logic [3:0]         alu;
    logic [2:0]         mem;
    logic [N-1:0]       rs1;
    logic [N-1:0]       rs2;
    logic [N-1:0]       rd;
  } dec_t;

  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;

  assign i  = in_instr;
  assign op = i[6:0];
  assign f3 = i[14:12];

  logic c_load, c_alu_imm, c_auipc, c_store, c_alu_reg;
  logic c_lui, c_branch, c_jalr, c_jal, c_system;

  always_comb begin
    c_load    = 1'b0;
    c_alu_imm = 1'b0;
    c_auipc   = 1'b0;
    c_store   = 1'b0;
    c_alu_reg = 1'b0;
    c_lui     = 1'b0;
    c_branch  = 1'b0;
    c_jalr    = 1'b0;
    c_jal     = 1'b0;
    c_system  = 1'b0;
    unique case (1'b1)
      (op == 7'b0000011): c_load    = 1'b1;
      (op == 7'b0010011): c_alu_imm = 1'b1;
      (op == 7'b0010111): c_auipc   = 1'b1;
      (op == 7'b0100011): c_store   = 1'b1;
      (op == 7'b0110011): c_alu_reg = 1'b1;
      (op == 7'b0110111): c_lui     = 1'b1;
      (op == 7'b1100011): c_branch  = 1'b1;
      (op == 7'b1100111): c_jalr    = 1'b1;
      (op == 7'b1101111): c_jal     = 1'b1;
      (op == 7'b1110011): c_system  = 1'b1;
      default: ;
    endcase
  end

  logic [9:0] cls;
  logic       known;
  logic       use_rd, use_rs1, use_rs2;
  logic       reg_bad, ill;

  assign cls = {c_load, c_alu_imm, c_auipc, c_store, c_alu_reg,
                c_lui, c_branch, c_jalr, c_jal, c_system};
  assign known   = |cls;
  assign use_rd  = known && !(c_store || c_branch);
  assign use_rs1 = c_load || c_alu_imm || c_store
                || c_alu_reg || c_branch || c_jalr;
  assign use_rs2 = c_store || c_alu_reg || c_branch;

  // RV32E has only x0..x15: bit 4 of any used register field is illegal
  assign reg_bad = RV32E && ((use_rd  && i[11])
                          || (use_rs1 && i[19])
                          || (use_rs2 && i[24]));
  assign ill = !known || reg_bad;

  logic [31:0] imm_d;

  always_comb begin
    imm_d = '0;
    unique case (1'b1)
      (c_load || c_alu_imm || c_jalr || c_system):
        imm_d = {{20{i[31]}}, i[31:20]};
      c_store:
        imm_d = {{20{i[31]}}, i[31:25], i[11:7]};
      c_branch:
        imm_d = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      (c_lui || c_auipc):
        imm_d = {i[31:12], 12'b0};
      c_jal:
        imm_d = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: ;
    endcase
  end

  logic [3:0] alu_d;

  always_comb begin
    alu_d = {1'b0, f3};
    if (c_alu_reg || (c_alu_imm && f3 == 3'b101))
      alu_d[3] = i[30];
  end

  dec_t dec;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.imm = imm_d;
    dec.cls = ill ? 10'b0 : cls;
    dec.ill = ill;
    dec.len = (i[1:0] == 2'b11) ? 3'd4 : 3'd2;
    dec.alu = alu_d;
    dec.mem = f3;
    dec.rs1 = i[15 +: N];
    dec.rs2 = i[20 +: N];
    dec.rd  = i[7 +: N];
  end

  dec_t main_q, skid_q;
  logic main_valid, skid_valid;
  logic accept;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign out_pc     = main_q.pc;
  assign imm        = main_q.imm;
  assign is_load    = main_q.cls[9];
  assign is_alu_imm = main_q.cls[8];
  assign is_auipc   = main_q.cls[7];
  assign is_store   = main_q.cls[6];
  assign is_alu_reg = main_q.cls[5];
  assign is_lui     = main_q.cls[4];
  assign is_branch  = main_q.cls[3];
  assign is_jalr    = main_q.cls[2];
  assign is_jal     = main_q.cls[1];
  assign is_system  = main_q.cls[0];
  assign is_illegal = main_q.ill;
  assign instr_len  = main_q.len;
  assign alu_op     = main_q.alu;
  assign mem_op     = main_q.mem;
  assign rs1        = main_q.rs1;
  assign rs2        = main_q.rs2;
  assign rd         = main_q.rd;

endmodule

// File: tb/tb_tinyqv_decode_stage.sv
// Bench for tinyqv_decode_stage: decode vector table, skid
// backpressure, flush and async reset, checked via a scoreboard.
module tb_tinyqv_decode_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [23:0] in_pc = '0;

  logic        in_ready, out_valid;
  logic [23:0] out_pc;
  logic [31:0] imm;
  logic        is_load, is_alu_imm, is_auipc, is_store, is_alu_reg;
  logic        is_lui, is_branch, is_jalr, is_jal, is_system;
  logic        is_illegal;
  logic [2:0]  instr_len, mem_op;
  logic [3:0]  alu_op;
  logic [3:0]  rs1, rs2, rd;

  logic        in_ready5, out_valid5;
  logic [23:0] out_pc5;
  logic [31:0] imm5;
  logic        ld5, ai5, au5, st5, ar5, lu5, br5, jr5, jl5, sy5;
  logic        ill5;
  logic [2:0]  len5, mem5;
  logic [3:0]  alu5;
  logic [4:0]  rs1_5, rs2_5, rd_5;

  always #5 clk = ~clk;

  tinyqv_decode_stage #(.REG_ADDR_BITS(4), .PC_BITS(24)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .imm(imm),
    .is_load(is_load), .is_alu_imm(is_alu_imm),
    .is_auipc(is_auipc), .is_store(is_store),
    .is_alu_reg(is_alu_reg), .is_lui(is_lui),
    .is_branch(is_branch), .is_jalr(is_jalr),
    .is_jal(is_jal), .is_system(is_system),
    .is_illegal(is_illegal), .instr_len(instr_len),
    .alu_op(alu_op), .mem_op(mem_op),
    .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  tinyqv_decode_stage #(.REG_ADDR_BITS(5), .PC_BITS(24)) dut5 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready5),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid5), .out_ready(out_ready),
    .out_pc(out_pc5), .imm(imm5),
    .is_load(ld5), .is_alu_imm(ai5),
    .is_auipc(au5), .is_store(st5),
    .is_alu_reg(ar5), .is_lui(lu5),
    .is_branch(br5), .is_jalr(jr5),
    .is_jal(jl5), .is_system(sy5),
    .is_illegal(ill5), .instr_len(len5),
    .alu_op(alu5), .mem_op(mem5),
    .rs1(rs1_5), .rs2(rs2_5), .rd(rd_5)
  );

  localparam logic [9:0] LD = 10'b1000000000;
  localparam logic [9:0] AI = 10'b0100000000;
  localparam logic [9:0] AU = 10'b0010000000;
  localparam logic [9:0] ST = 10'b0001000000;
  localparam logic [9:0] AR = 10'b0000100000;
  localparam logic [9:0] LU = 10'b0000010000;
  localparam logic [9:0] BR = 10'b0000001000;
  localparam logic [9:0] JR = 10'b0000000100;
  localparam logic [9:0] JL = 10'b0000000010;
  localparam logic [9:0] SY = 10'b0000000001;
  localparam logic [9:0] NO = 10'b0000000000;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  cls;
    logic        ill;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  mem;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [2:0]  len;
    logic        chk5;
    logic [9:0]  cls5;
    logic [4:0]  rd5;
    logic [4:0]  rs1_5;
    logic [4:0]  rs2_5;
    logic [23:0] pc;
  } vec_t;

  vec_t tbl[16];
  vec_t q[$];
  vec_t cur_exp;
  int   total = 0;
  int   bad = 0;
  int   pops = 0;

  function automatic vec_t mk(
    logic [31:0] ins, logic [9:0] c, logic il, logic [31:0] im,
    logic [3:0] al, logic [2:0] me, logic [3:0] d, logic [3:0] s1,
    logic [3:0] s2, logic [2:0] ln, logic k5, logic [9:0] c5,
    logic [4:0] d5, logic [4:0] s15, logic [4:0] s25);
    vec_t v;
    v.instr = ins; v.cls = c; v.ill = il; v.imm = im;
    v.alu = al; v.mem = me; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.len = ln; v.chk5 = k5; v.cls5 = c5; v.rd5 = d5;
    v.rs1_5 = s15; v.rs2_5 = s25; v.pc = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] dout();
    return {is_load, is_alu_imm, is_auipc, is_store, is_alu_reg,
            is_lui, is_branch, is_jalr, is_jal, is_system,
            is_illegal, imm, alu_op, mem_op, rd, rs1, rs2,
            instr_len, out_pc};
  endfunction

  function automatic logic [127:0] expv(vec_t v);
    return {v.cls, v.ill, v.imm, v.alu, v.mem, v.rd, v.rs1, v.rs2,
            v.len, v.pc};
  endfunction

  // Pop before push: the queue head is always the main entry.
  task automatic mon();
    vec_t e;
    if (!rstn || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {1'b1, out_pc}, {1'b0, out_pc});
        end else begin
          e = q.pop_front();
          pops++;
          chk($sformatf("dec_pc%0h", e.pc), dout(), expv(e));
          if (e.chk5)
            chk($sformatf("rv32i_pc%0h", e.pc),
                {ld5, ai5, au5, st5, ar5, lu5, br5, jr5, jl5, sy5,
                 ill5, rd_5, rs1_5, rs2_5, imm5, alu5, mem5, len5,
                 out_pc5, out_valid5, in_ready5},
                {e.cls5, 1'b0, e.rd5, e.rs1_5, e.rs2_5, e.imm,
                 e.alu, e.mem, e.len, e.pc, 1'b1, 1'b1});
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [23:0] pc);
    in_instr = v.instr;
    in_pc    = pc;
    cur_exp  = v;
    cur_exp.pc = pc;
    in_valid = 1'b1;
  endtask

  initial begin
    int p0;
    tbl[0]  = mk(32'hFFF00293, AI, 0, 32'hFFFFFFFF, 4'h0, 3'd0,
                 4'd5, 4'd0, 4'hF, 3'd4, 0, NO, 0, 0, 0);
    tbl[1]  = mk(32'h40208033, AR, 0, 32'h0, 4'h8, 3'd0,
                 4'd0, 4'd1, 4'd2, 3'd4, 0, NO, 0, 0, 0);
    tbl[2]  = mk(32'h001000EF, JL, 0, 32'h00000800, 4'h0, 3'd0,
                 4'd1, 4'd0, 4'd1, 3'd4, 0, NO, 0, 0, 0);
    tbl[3]  = mk(32'h002088B3, NO, 1, 32'h0, 4'h0, 3'd0,
                 4'd1, 4'd1, 4'd2, 3'd4, 1, AR, 5'd17, 5'd1, 5'd2);
    tbl[4]  = mk(32'h00004501, NO, 1, 32'h0, 4'h4, 3'd4,
                 4'd10, 4'd0, 4'd0, 3'd2, 0, NO, 0, 0, 0);
    tbl[5]  = mk(32'h0000007F, NO, 1, 32'h0, 4'h0, 3'd0,
                 4'd0, 4'd0, 4'd0, 3'd4, 0, NO, 0, 0, 0);
    tbl[6]  = mk(32'hFFC12303, LD, 0, 32'hFFFFFFFC, 4'h2, 3'd2,
                 4'd6, 4'd2, 4'hC, 3'd4, 0, NO, 0, 0, 0);
    tbl[7]  = mk(32'hFE322E23, ST, 0, 32'hFFFFFFFC, 4'h2, 3'd2,
                 4'hC, 4'd4, 4'd3, 3'd4, 0, NO, 0, 0, 0);
    tbl[8]  = mk(32'hFE208CE3, BR, 0, 32'hFFFFFFF8, 4'h0, 3'd0,
                 4'd9, 4'd1, 4'd2, 3'd4, 0, NO, 0, 0, 0);
    tbl[9]  = mk(32'h123453B7, LU, 0, 32'h12345000, 4'h5, 3'd5,
                 4'd7, 4'd8, 4'd3, 3'd4, 0, NO, 0, 0, 0);
    tbl[10] = mk(32'h40335293, AI, 0, 32'h00000403, 4'hD, 3'd5,
                 4'd5, 4'd6, 4'd3, 3'd4, 0, NO, 0, 0, 0);
    tbl[11] = mk(32'hFFFFF097, AU, 0, 32'hFFFFF000, 4'h7, 3'd7,
                 4'd1, 4'hF, 4'hF, 3'd4, 0, NO, 0, 0, 0);
    tbl[12] = mk(32'h00008067, JR, 0, 32'h0, 4'h0, 3'd0,
                 4'd0, 4'd1, 4'd0, 3'd4, 0, NO, 0, 0, 0);
    tbl[13] = mk(32'h00000073, SY, 0, 32'h0, 4'h0, 3'd0,
                 4'd0, 4'd0, 4'd0, 3'd4, 0, NO, 0, 0, 0);
    tbl[14] = mk(32'h00082083, NO, 1, 32'h0, 4'h2, 3'd2,
                 4'd1, 4'd0, 4'd0, 3'd4, 1, LD, 5'd1, 5'd16, 5'd0);
    tbl[15] = mk(32'h012100B3, NO, 1, 32'h0, 4'h0, 3'd0,
                 4'd1, 4'd2, 4'd2, 3'd4, 1, AR, 5'd1, 5'd2, 5'd18);
    cur_exp = tbl[0];

    fork
      forever begin
        @(negedge clk);
        mon();
      end
      begin
        repeat (3000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL timeout: run did not complete");
      end
      begin
        // reset state
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_data", dout(), '0);
        tick();
        rstn = 1'b1;
        tick();

        // decode table at full throughput
        out_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 16; k++) begin
          drive(tbl[k], 24'h001000 + 24'(4 * k));
          tick();
          if (k == 0) chk("latency", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("throughput", pops - p0, 16);
        chk("drained", out_valid, 1'b0);

        // backpressure: PCs 0,4,8,12
        out_ready = 1'b0;
        drive(tbl[0], 24'd0);
        chk("bp_ready0", in_ready, 1'b1);
        tick();
        chk("bp_valid1", out_valid, 1'b1);
        chk("bp_ready1", in_ready, 1'b1);
        drive(tbl[0], 24'd4);
        tick();
        chk("bp_full", in_ready, 1'b0);
        chk("bp_hold2", out_pc, 24'd0);
        drive(tbl[0], 24'd8);
        tick();
        chk("bp_full3", in_ready, 1'b0);
        chk("bp_hold3", out_pc, 24'd0);
        out_ready = 1'b1;
        tick();
        chk("rel_pc4", {out_valid, out_pc}, {1'b1, 24'd4});
        chk("rel_ready", in_ready, 1'b1);
        tick();
        chk("rel_pc8", {out_valid, out_pc}, {1'b1, 24'd8});
        drive(tbl[0], 24'd12);
        tick();
        in_valid = 1'b0;
        chk("rel_pc12", {out_valid, out_pc}, {1'b1, 24'd12});
        tick();
        chk("rel_empty", out_valid, 1'b0);

        // flush with both entries full
        out_ready = 1'b0;
        drive(tbl[1], 24'h100);
        tick();
        drive(tbl[2], 24'h104);
        tick();
        chk("fl_full", {out_valid, in_ready}, {1'b1, 1'b0});
        drive(tbl[6], 24'h108);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty", {out_valid, in_ready}, {1'b0, 1'b1});
        // flush while an accept would happen
        drive(tbl[7], 24'h200);
        tick();
        drive(tbl[8], 24'h204);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_acc_empty", {out_valid, in_ready}, {1'b0, 1'b1});
        out_ready = 1'b1;
        drive(tbl[9], 24'h10C);
        tick();
        in_valid = 1'b0;
        chk("fl_next", {out_valid, out_pc}, {1'b1, 24'h10C});
        tick();
        chk("fl_done", {out_valid, 32'(q.size())}, '0);

        // async reset mid-stream
        out_ready = 1'b0;
        drive(tbl[10], 24'h300);
        tick();
        drive(tbl[11], 24'h304);
        tick();
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("ar_state", {out_valid, in_ready}, {1'b0, 1'b1});
        chk("ar_data", dout(), '0);
        tick();
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        drive(tbl[12], 24'h400);
        tick();
        in_valid = 1'b0;
        chk("ar_next", {out_valid, out_pc}, {1'b1, 24'h400});
        tick();
        chk("ar_done", {out_valid, 32'(q.size())}, '0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
